// File: rtl/park_level_ctrl.sv
// park_level_ctrl: parking occupancy counter with entry grant/reject and a
// stepping level state machine that tracks the highest occupied level.
// Optional build macro: PARK_LEVEL_HYST_EN (adds one-space hysteresis to
// downward level steps so a car toggling at a level boundary does not flap
// the level output).
module park_level_ctrl #(
  parameter int NUM_LEVELS       = 3,
  parameter int SPACES_PER_LEVEL = 4,
  parameter int CNT_W            = 4,
  parameter int LVL_W            = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_car_in,
  input  logic             i_car_out,
  output logic             o_entry_gnt,
  output logic             o_entry_rej,
  output logic [CNT_W-1:0] o_count,
  output logic [LVL_W-1:0] o_level,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_err
);

  localparam int               CAP     = NUM_LEVELS * SPACES_PER_LEVEL;
  localparam logic [CNT_W-1:0] CAP_V   = CNT_W'(CAP);
  localparam logic [CNT_W-1:0] ONE_V   = CNT_W'(1);
  localparam logic [LVL_W-1:0] LVL_TOP = LVL_W'(NUM_LEVELS - 1);

  // FULL is a separate mode; within LVL mode the level index is r_lvl.
  // Unused encodings of the mode register fall back to LVL(0).
  typedef enum logic [1:0] {
    ST_LVL  = 2'b00,
    ST_FULL = 2'b01
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [LVL_W-1:0] r_lvl;
  logic [LVL_W-1:0] w_lvl_next;
  logic [CNT_W-1:0] r_count;
  logic             r_entry_gnt;
  logic             r_entry_rej;
  logic             r_err;

  logic w_out_ok;
  logic w_in_ok;
  int   w_cnt_i;
  int   w_lvl_i;
  int   w_tgt;
  int   w_down_thr;

  // A valid exit frees a space, so an entry in the same cycle is accepted
  // even when the lot is full.
  assign w_out_ok = i_car_out && (r_count != '0);
  assign w_in_ok  = i_car_in && ((r_count < CAP_V) || w_out_ok);

  // Occupancy counter plus registered grant/reject pulses and sticky error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count     <= '0;
      r_entry_gnt <= 1'b0;
      r_entry_rej <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_in_ok && !w_out_ok) begin
        r_count <= r_count + ONE_V;
      end else if (!w_in_ok && w_out_ok) begin
        r_count <= r_count - ONE_V;
      end
      r_entry_gnt <= w_in_ok;
      r_entry_rej <= i_car_in && !w_in_ok;
      if (i_car_out && (r_count == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Level state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_LVL;
      r_lvl   <= '0;
    end else begin
      r_state <= w_state_next;
      r_lvl   <= w_lvl_next;
    end
  end

  // Next-state logic: step at most one level per cycle toward the target
  // level derived from the registered count.
  always_comb begin
    w_state_next = r_state;
    w_lvl_next   = r_lvl;
    w_cnt_i      = int'(r_count);
    w_lvl_i      = int'(r_lvl);
    w_tgt        = (r_count == '0) ? 0 : (w_cnt_i - 1) / SPACES_PER_LEVEL;
`ifdef PARK_LEVEL_HYST_EN
    w_down_thr   = w_lvl_i * SPACES_PER_LEVEL - 1;
`else
    w_down_thr   = w_lvl_i * SPACES_PER_LEVEL;
`endif
    case (r_state)
      ST_LVL: begin
        if (r_lvl > LVL_TOP) begin
          w_lvl_next = '0;
        end else if ((r_lvl == LVL_TOP) && (r_count == CAP_V)) begin
          w_state_next = ST_FULL;
        end else if (w_tgt > w_lvl_i) begin
          w_lvl_next = r_lvl + LVL_W'(1);
        end else if ((r_lvl != '0) && (w_cnt_i <= w_down_thr)) begin
          w_lvl_next = r_lvl - LVL_W'(1);
        end
      end
      ST_FULL: begin
        w_lvl_next = LVL_TOP;
        if (r_count < CAP_V) begin
          w_state_next = ST_LVL;
        end
      end
      default: begin
        w_state_next = ST_LVL;
        w_lvl_next   = '0;
      end
    endcase
  end

  assign o_count     = r_count;
  assign o_level     = r_lvl;
  assign o_entry_gnt = r_entry_gnt;
  assign o_entry_rej = r_entry_rej;
  assign o_err       = r_err;
  assign o_full      = (r_state == ST_FULL);
  assign o_empty     = (r_count == '0);

endmodule

// File: doc/park_level_ctrl.md
# park_level_ctrl

Parametrised parking occupancy and level controller. It counts cars itself from entry and exit sensor pulses, instead of taking an external count. It grants or rejects each entry and tracks the highest occupied level with a stepping state machine. It sits between the gate sensors and the level display and barrier logic, and generalises the fixed 3-level, 4-space level FSM to any level count and capacity.

## Interface
- `NUM_LEVELS`, default 3: number of levels, minimum 2.
- `SPACES_PER_LEVEL`, default 4: spaces per level, minimum 1.
- `CNT_W`, default 4: occupancy counter width; must satisfy 2^CNT_W > NUM_LEVELS*SPACES_PER_LEVEL.
- `LVL_W`, default 2: level index width; must satisfy 2^LVL_W ≥ NUM_LEVELS.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `car_in` in 1: entry request, one-cycle pulse per car.
- `car_out` in 1: exit event, one-cycle pulse per car.
- `entry_gnt` out 1: registered one-cycle pulse; entry accepted.
- `entry_rej` out 1: registered one-cycle pulse; entry refused because the lot is full.
- `count` out CNT_W: registered occupancy.
- `level` out LVL_W: registered highest occupied level index.
- `full` out 1: occupancy equals CAP.
- `empty` out 1: occupancy is 0.
- `err` out 1: sticky flag; an exit arrived while empty.

## Operation
- CAP = NUM_LEVELS*SPACES_PER_LEVEL.
- Exit valid: out_ok = car_out && count>0.
  - car_out with count==0 sets `err` and leaves `count` unchanged.
- Entry valid: in_ok = car_in && (count<CAP || out_ok).
  - A simultaneous valid exit frees a space for the entering car.
  - car_in && !in_ok pulses `entry_rej`.
- count_next = count + in_ok − out_ok. It never exceeds CAP and never goes below 0.
- Simultaneous in_ok and out_ok: count is unchanged and `entry_gnt` pulses.
- Target level: tgt = 0 if count==0, else (count−1)/SPACES_PER_LEVEL.
  - Defaults: 0–4 → 0, 5–8 → 1, 9–12 → 2.
- Level FSM states: LVL(k) for k = 0..NUM_LEVELS−1, plus FULL.
  - LVL(k) → LVL(k+1) when tgt>k.
  - LVL(k) → LVL(k−1) when tgt<k (see Configuration).
  - The FSM moves at most one level per cycle.
  - LVL(NUM_LEVELS−1) → FULL when count==CAP.
  - FULL → LVL(NUM_LEVELS−1) when count<CAP.
  - FULL reports level NUM_LEVELS−1.
  - An out-of-range state register recovers to LVL(0) on the next clock.
- `full` = state==FULL. `empty` = count==0, decoded from the register.
- `err` is cleared only by `rst`.

## Timing
- Reset values, applied asynchronously: count=0, level=0, state LVL(0), entry_gnt=0, entry_rej=0, err=0, full=0, empty=1.
- Reset mid-operation discards occupancy; counting restarts from 0 after deassertion.
- `count`, `entry_gnt`, `entry_rej` and `err` update on the first rising edge after the sampled pulse (latency 1).
- The level FSM samples registered `count`.
  - `level` follows a one-level change 1 cycle after `count`.
  - A jump of N levels (after reset) settles after N cycles.
- `full` asserts 1 cycle after `count` reaches CAP and deasserts 1 cycle after it drops below.
- `empty` follows `count` in the same cycle.
- Back-to-back pulses on consecutive cycles are each counted; there is no throughput limit.

## Configuration
- Macro `PARK_LEVEL_HYST_EN`.
- Without it: LVL(k) → LVL(k−1) when count ≤ k*SPACES_PER_LEVEL, i.e. as soon as level k is empty.
- With it: LVL(k) → LVL(k−1) only when count ≤ k*SPACES_PER_LEVEL − 1. A single car toggling at a boundary then does not flap `level`.
- Upward transitions and FULL behaviour are identical in both builds.

## Test plan
- All tests use default parameters (CAP = 12).
- Reset, then 12 car_in pulses: count reaches 12; 12 `entry_gnt` pulses; `level` goes 0→1 after entry 5 and 1→2 after entry 9; `full`=1 one cycle after count=12.
- At count=12, a 13th car_in: one `entry_rej`, no `entry_gnt`, count stays 12. Then car_in and car_out in the same cycle: `entry_gnt` pulses, count stays 12, `full` stays 1.
- Count 0, car_out: `err`=1 and stays 1 after later traffic; count stays 0, `empty` stays 1.
- Count 5, level 1, one car_out: count=4.
  - Without the macro: `level`=0 next cycle.
  - With `PARK_LEVEL_HYST_EN`: `level` stays 1 until count=3.
- Count 10, assert `rst` between clock edges: all outputs reach reset values immediately, without waiting for a clock edge. After release, a single car_in gives count=1.
- Count 4, car_in pulses on 3 consecutive cycles: count 5, 6, 7 on successive cycles; `level`=1 one cycle after count=5.
